// File: rtl/lms_fir_error_if.sv
// rtl/lms_fir_error_if.sv - sample/desired input and filter/error output bundle for lms_fir_error
interface lms_fir_error_if #(
  parameter int DW = 16
);
  logic                 in_valid;
  logic signed [DW-1:0] data_in;
  logic signed [DW-1:0] desired_in;
  logic signed [DW-1:0] y_out;
  logic signed [DW-1:0] error_o;
  logic                 out_valid;
  logic                 primed;

  modport master (
    output in_valid, data_in, desired_in,
    input  y_out, error_o, out_valid, primed
  );

  modport slave (
    input  in_valid, data_in, desired_in,
    output y_out, error_o, out_valid, primed
  );
endinterface

// File: rtl/lms_fir_error.sv
// rtl/lms_fir_error.sv - 9-tap adaptive FIR with rounded/saturated output and d - y error stage
module lms_fir_error #(
  parameter int DW        = 16,
  parameter int CW        = 16,
  parameter int COEF_FRAC = 14,
  parameter int NTAP      = 9
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  lms_fir_error_if.slave       bus,
  input  logic signed [CW-1:0] coef1,
  input  logic signed [CW-1:0] coef2,
  input  logic signed [CW-1:0] coef3,
  input  logic signed [CW-1:0] coef4,
  input  logic signed [CW-1:0] coef5,
  input  logic signed [CW-1:0] coef6,
  input  logic signed [CW-1:0] coef7,
  input  logic signed [CW-1:0] coef8,
  input  logic signed [CW-1:0] coef9
);
  localparam int PW = DW + CW;
  localparam int SW = PW + 4;
  localparam int AW = SW + 1;
  localparam logic signed [AW-1:0] RND   = {{(AW-COEF_FRAC){1'b0}}, 1'b1, {(COEF_FRAC-1){1'b0}}};
  localparam logic signed [AW-1:0] MAX_A = {{(AW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [AW-1:0] MIN_A = {{(AW-DW+1){1'b1}}, {(DW-1){1'b0}}};
  localparam logic signed [DW-1:0] MAX_D = {1'b0, {(DW-1){1'b1}}};
  localparam logic signed [DW-1:0] MIN_D = {1'b1, {(DW-1){1'b0}}};

  logic signed [CW-1:0] coef [NTAP];
  logic signed [DW-1:0] tap  [NTAP];
  logic signed [PW-1:0] prod [NTAP];
  logic signed [SW-1:0] psum_a, psum_b, sum_a, sum_b;
  logic signed [AW-1:0] acc, shifted;
  logic signed [DW-1:0] y_next, y3;
  logic signed [DW-1:0] d0, d1, d2, d3;
  logic signed [DW:0]   diff;
  logic signed [DW-1:0] err_next;
  logic signed [DW-1:0] y_q, err_q;
  logic [4:0]           vpipe;
  logic [3:0]           fill_cnt;
  logic                 primed_q;

  assign coef[0] = coef1;
  assign coef[1] = coef2;
  assign coef[2] = coef3;
  assign coef[3] = coef4;
  assign coef[4] = coef5;
  assign coef[5] = coef6;
  assign coef[6] = coef7;
  assign coef[7] = coef8;
  assign coef[8] = coef9;

  always_comb begin
    sum_a = '0;
    sum_b = '0;
    for (int i = 0; i < 5; i++)
      sum_a = sum_a + {{4{prod[i][PW-1]}}, prod[i]};
    for (int i = 5; i < NTAP; i++)
      sum_b = sum_b + {{4{prod[i][PW-1]}}, prod[i]};
  end

  // Round half-up: add half an LSB of the output scale, then arithmetic shift.
  always_comb begin
    acc     = {psum_a[SW-1], psum_a} + {psum_b[SW-1], psum_b} + RND;
    shifted = acc >>> COEF_FRAC;
    if (shifted > MAX_A)
      y_next = MAX_D;
    else if (shifted < MIN_A)
      y_next = MIN_D;
    else
      y_next = shifted[DW-1:0];
  end

  always_comb begin
    diff = {d3[DW-1], d3} - {y3[DW-1], y3};
    if (diff[DW] != diff[DW-1])
      err_next = diff[DW] ? MIN_D : MAX_D;
    else
      err_next = diff[DW-1:0];
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NTAP; i++) begin
        tap[i]  <= '0;
        prod[i] <= '0;
      end
      psum_a   <= '0;
      psum_b   <= '0;
      y3       <= '0;
      d0       <= '0;
      d1       <= '0;
      d2       <= '0;
      d3       <= '0;
      y_q      <= '0;
      err_q    <= '0;
      vpipe    <= '0;
      fill_cnt <= '0;
      primed_q <= 1'b0;
    end else begin
      if (bus.in_valid) begin
        tap[0] <= bus.data_in;
        for (int i = 1; i < NTAP; i++)
          tap[i] <= tap[i-1];
        d0 <= bus.desired_in;
        if (fill_cnt != 4'd9)
          fill_cnt <= fill_cnt + 4'd1;
        if (fill_cnt == 4'd8)
          primed_q <= 1'b1;
      end
      for (int i = 0; i < NTAP; i++)
        prod[i] <= tap[i] * coef[i];
      psum_a <= sum_a;
      psum_b <= sum_b;
      y3     <= y_next;
      d1     <= d0;
      d2     <= d1;
      d3     <= d2;
      vpipe  <= {vpipe[3:0], bus.in_valid};
      if (vpipe[3]) begin
        y_q   <= y3;
        err_q <= err_next;
      end
    end
  end

  assign bus.y_out     = y_q;
  assign bus.error_o   = err_q;
  assign bus.out_valid = vpipe[4];
  assign bus.primed    = primed_q;
endmodule

// File: tb/tb_lms_fir_error.sv
// tb/tb_lms_fir_error.sv - directed vector bench for lms_fir_error
module tb_lms_fir_error;
  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  logic signed [15:0] c [9];

  lms_fir_error_if #(.DW(16)) bus ();

  lms_fir_error dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus.slave),
    .coef1 (c[0]),
    .coef2 (c[1]),
    .coef3 (c[2]),
    .coef4 (c[3]),
    .coef5 (c[4]),
    .coef6 (c[5]),
    .coef7 (c[6]),
    .coef8 (c[7]),
    .coef9 (c[8])
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    int c1;
    int data;
    int des;
    int ey;
    int ee;
  } vec_t;

  int n_app = 0;
  int n_mis = 0;
  int q_y[$];
  int q_e[$];

  always @(negedge clk_i)
    if (bus.out_valid) begin
      q_y.push_back(int'(bus.y_out));
      q_e.push_back(int'(bus.error_o));
    end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    n_app++;
    if (act != exp) begin
      n_mis++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    bus.in_valid = 1'b0;
    rst_i = 1'b1;
    tick();
    tick();
    rst_i = 1'b0;
    tick();
  endtask

  task automatic set_coefs(input int base, input int step);
    for (int i = 0; i < 9; i++)
      c[i] = 16'(base + step * (i + 1));
  endtask

  task automatic send(input int data, input int des);
    bus.in_valid   = 1'b1;
    bus.data_in    = 16'(data);
    bus.desired_in = 16'(des);
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      tick();
  endtask

  vec_t vt [8];

  initial begin
    int lat;
    vt[0] = '{16384,   1000,   1500,   1000,    500};
    vt[1] = '{ 8192,      3,      0,      2,     -2};
    vt[2] = '{ 8192,     -3,      0,     -1,      1};
    vt[3] = '{ 8192,      1,      0,      1,     -1};
    vt[4] = '{ 8192,     -1,      5,      0,      5};
    vt[5] = '{ 4096,      6,      0,      2,     -2};
    vt[6] = '{16384, -32768,  32767, -32768,  32767};
    vt[7] = '{16384,    100, -32768,    100, -32768};

    bus.in_valid   = 1'b0;
    bus.data_in    = '0;
    bus.desired_in = '0;
    set_coefs(0, 0);
    do_reset();
    chk("reset_y", int'(bus.y_out), 0);
    chk("reset_err", int'(bus.error_o), 0);
    chk("reset_vld", int'(bus.out_valid), 0);
    chk("reset_primed", int'(bus.primed), 0);

    // Only coef1 nonzero, so each output depends on the newest sample alone.
    for (int v = 0; v < 8; v++) begin
      c[0] = 16'(vt[v].c1);
      send(vt[v].data, vt[v].des);
      lat = 99;
      for (int t = 1; t <= 10; t++) begin
        tick();
        if (bus.out_valid) begin
          lat = t;
          break;
        end
      end
      chk($sformatf("vec%0d_latency", v), lat, 4);
      chk($sformatf("vec%0d_y", v), int'(bus.y_out), vt[v].ey);
      chk($sformatf("vec%0d_err", v), int'(bus.error_o), vt[v].ee);
    end
    idle(3);
    chk("hold_y", int'(bus.y_out), 100);
    chk("hold_err", int'(bus.error_o), -32768);

    // Impulse through coef_i = i*1000.
    do_reset();
    set_coefs(0, 1000);
    q_y.delete();
    q_e.delete();
    send(16384, 0);
    for (int i = 1; i < 8; i++)
      send(0, 0);
    chk("impulse_primed_at8", int'(bus.primed), 0);
    send(0, 0);
    chk("impulse_primed_at9", int'(bus.primed), 1);
    idle(8);
    chk("impulse_count", q_y.size(), 9);
    for (int i = 0; i < 9; i++)
      chk($sformatf("impulse_y%0d", i), (i < q_y.size()) ? q_y[i] : -99999, 1000 * (i + 1));

    // Saturation with every weight at 1.0.
    do_reset();
    set_coefs(16384, 0);
    q_y.delete();
    q_e.delete();
    for (int i = 0; i < 9; i++)
      send(20000, -32768);
    idle(8);
    chk("sat_count", q_y.size(), 9);
    chk("sat_first_y", (q_y.size() > 0) ? q_y[0] : -99999, 20000);
    chk("sat_first_err", (q_e.size() > 0) ? q_e[0] : -99999, -32768);
    chk("sat_last_y", (q_y.size() == 9) ? q_y[8] : -99999, 32767);
    chk("sat_last_err", (q_e.size() == 9) ? q_e[8] : -99999, -32768);

    // Gap in in_valid must not shift the delay line.
    do_reset();
    set_coefs(0, 0);
    c[0] = 16'sd16384;
    c[1] = 16'sd16384;
    q_y.delete();
    q_e.delete();
    send(100, 0);
    idle(3);
    send(200, 0);
    idle(8);
    chk("gap_count", q_y.size(), 2);
    chk("gap_y0", (q_y.size() > 0) ? q_y[0] : -99999, 100);
    chk("gap_y1", (q_y.size() > 1) ? q_y[1] : -99999, 300);
    chk("gap_err1", (q_e.size() > 1) ? q_e[1] : -99999, -300);

    // Reset two cycles after a valid flushes the pipe and the fill counter.
    do_reset();
    set_coefs(0, 0);
    c[0] = 16'sd16384;
    q_y.delete();
    q_e.delete();
    send(500, 700);
    idle(1);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    idle(8);
    chk("rstmid_pulses", q_y.size(), 0);
    chk("rstmid_y", int'(bus.y_out), 0);
    chk("rstmid_err", int'(bus.error_o), 0);
    chk("rstmid_primed", int'(bus.primed), 0);
    for (int i = 0; i < 8; i++)
      send(i, 0);
    chk("rstmid_primed_at8", int'(bus.primed), 0);
    send(8, 0);
    chk("rstmid_primed_at9", int'(bus.primed), 1);
    idle(6);
    chk("rstmid_out_count", q_y.size(), 9);
    chk("rstmid_last_y", (q_y.size() == 9) ? q_y[8] : -99999, 8);

    $display("== %0d vectors applied, %0d miscompares ==", n_app, n_mis);
    $finish;
  end
endmodule

// File: doc/lms_fir_error.md
Name: lms_fir_error

Overview:
- 9-tap adaptive FIR datapath plus error stage; sits directly upstream of the LMS coefficient-update stage.
- Filters the input sample stream with the live coefficients coef1..coef9 and computes the error desired - y.
- Drives error_o back to the coefficient-update stage.
- Fully pipelined; accepts one sample per clock when in_valid is high.

Parameters:
- DW, 16, data, desired and output width (signed).
- CW, 16, coefficient width (signed).
- COEF_FRAC, 14, fractional bits of the coefficients (Q1.14 at default).
- NTAP, 9, tap count; fixed at 9, because the ports are enumerated.

Ports:
- clk_i  in  1  clock; all logic on rising edge.
- rst_i  in  1  asynchronous reset, active-high.
- in_valid  in  1  data_in/desired_in qualify.
- data_in  in  DW  signed input sample x[n].
- desired_in  in  DW  signed reference d[n], paired with data_in.
- coef1..coef9  in  CW each  signed live weights; coef1 multiplies the newest tap.
- y_out  out  DW  signed filter output, saturated.
- error_o  out  DW  signed error d - y, saturated; feeds the update stage.
- out_valid  out  1  one-cycle strobe; y_out/error_o are new.
- primed  out  1  high once 9 samples have entered the delay line.

Behaviour:
- Reset (async assert, sync release): all taps, pipeline registers, y_out, error_o, out_valid, primed and fill counter go to 0.
- Delay line tap0..tap8:
  - Shifts only on edges where in_valid=1: tap0<=data_in, tapk<=tap(k-1).
  - Holds when in_valid=0; gaps in in_valid do not shift the line.
- Pipeline, in_valid sampled at edge k:
  - k: taps load; desired_in captured into the alignment pipe; v0=1.
  - k+1: prod_i <= tap(i-1) * coef_i, 2*DW-bit signed, i=1..9. Coefficients are sampled at this edge.
  - k+2: psum_a <= prod1+..+prod5; psum_b <= prod6+..+prod9 (2*DW+4 bits, no overflow possible).
  - k+3: acc = psum_a + psum_b. y <= sat_DW((acc + 2^(COEF_FRAC-1)) >>> COEF_FRAC), i.e. round-half-up arithmetic shift.
  - k+4: error_o <= sat_DW(desired_aligned - y), computed at DW+1 bits; y_out <= y; out_valid=1 for exactly that cycle.
- Latency: in_valid at edge k gives out_valid high after edge k+4. Throughput is 1 sample/clk.
- Back-to-back valids produce back-to-back out_valid, with no bubbles inserted.
- y_out and error_o hold their last values while out_valid=0.
- The valid pipe is a 5-bit shift register. Pipeline data registers may update unconditionally; outputs update only when the stage-4 valid is set.
- Saturation: clamp to [-2^(DW-1), 2^(DW-1)-1]; no wrap-around ever.
- primed:
  - A 4-bit fill counter increments on each in_valid until it reaches 9, then holds (no wrap).
  - primed=1 when the counter reaches 9.
  - The counter clears only on reset.
  - out_valid is not gated by primed.
- Reset mid-operation flushes all in-flight samples; no out_valid is produced for samples accepted before reset.
- Coefficient changes mid-stream take effect for every sample whose k+1 edge occurs after the change. No coefficient double-buffering.

Test Plan:
- Reset, then coef1=16384 (1.0), others 0; data_in=1000, desired_in=1500, one valid -> 4 cycles later out_valid=1, y_out=1000, error_o=500.
- Impulse: coef_i=i*1000; one sample data=16384, then 8 samples data=0 -> y_out sequence 1000,2000,...,9000 on consecutive out_valid; primed rises with the 9th input.
- Saturation: all coefs 16384, 9 samples of data=20000, desired=-32768 -> y_out=32767, error_o=-32768 (no wrap).
- Rounding: coef1=8192, data=3 -> y_out=2; data=-3 -> y_out=-1; data=1 -> y_out=1.
- Valid gaps: samples 100, (gap 3 cycles), 200 with coef1=coef2=16384 -> second output=300; exactly 2 out_valid pulses, and the line does not shift during the gap.
- Assert rst_i 2 cycles after a valid -> outputs 0, no out_valid pulse; primed=0, and the counter restarts from 0.
